// File: rtl/lcd_bus_responder.sv
// lcd_bus_responder
// Responder end of an HD44780-style 8-bit character-LCD bus. It watches the
// initiator's EN/RS/RW/DATA lines, decodes instruction and data writes into a
// 2x16 DDRAM image, and answers read cycles with the busy flag, the address
// counter and DDRAM contents.
//
// Optional feature macro: LCD_RESP_BUSY_EN
//   defined     - busy counter is built; writes committing while busy are
//                 rejected and flag err.
//   not defined - busy is constant 0 and every write is accepted.
//
// Ports
//   CLOCK_50      in   system clock, all logic on the rising edge
//   rst           in   synchronous active-high reset
//   lcd_en        in   bus enable from the initiator
//   lcd_rs        in   0 = instruction/status, 1 = data
//   lcd_rw        in   0 = write, 1 = read
//   lcd_data_in   in   [7:0] bus data from the initiator
//   lcd_data_out  out  [7:0] read data, valid while data_oe = 1
//   data_oe       out  high (registered) while lcd_en = 1 and lcd_rw = 1
//   ddram_flat    out  [255:0] line0 col k at [255-8k -: 8], line1 col k at [127-8k -: 8]
//   ac            out  [6:0] address counter
//   display_on, cursor_on, blink_on  out  display-control flags
//   busy          out  busy flag
//   err           out  sticky protocol-error flag, cleared only by rst
module lcd_bus_responder #(
    parameter int BUSY_SHORT = 2000,
    parameter int BUSY_LONG  = 82000
) (
    input  logic         CLOCK_50,
    input  logic         rst,
    input  logic         lcd_en,
    input  logic         lcd_rs,
    input  logic         lcd_rw,
    input  logic [7:0]   lcd_data_in,
    output logic [7:0]   lcd_data_out,
    output logic         data_oe,
    output logic [255:0] ddram_flat,
    output logic [6:0]   ac,
    output logic         display_on,
    output logic         cursor_on,
    output logic         blink_on,
    output logic         busy,
    output logic         err
);

    // Bus capture: rs/rw/data are held from the last cycle EN was high.
    logic       en_q_r;
    logic       rs_q_r;
    logic       rw_q_r;
    logic [7:0] data_q_r;

    // Display state.
    logic [7:0] ddram_r [0:31];
    logic [6:0] ac_r;
    logic       id_r;
    logic       cg_mode_r;
    logic       display_on_r;
    logic       cursor_on_r;
    logic       blink_on_r;
    logic       err_r;
    logic [7:0] data_out_r;
    logic       data_oe_r;

    logic       busy_s;
    logic       commit_s;
    logic       accept_s;
    logic [7:0] rd_data_s;

    // Only 0x00-0x0F and 0x40-0x4F hold characters: bits 5:4 must be clear.
    function automatic logic is_mapped(input logic [6:0] a);
        return (a[5:4] == 2'b00);
    endfunction

    // Line select comes from bit 6, column from bits 3:0.
    function automatic logic [4:0] ram_idx(input logic [6:0] a);
        return {a[6], a[3:0]};
    endfunction

    // Address-counter step, wrapping between the two visible line windows.
    function automatic logic [6:0] step_ac(input logic [6:0] a, input logic inc);
        logic [6:0] n;
        if (inc) begin
            if (a == 7'h0F) begin
                n = 7'h40;
            end else if (a == 7'h4F) begin
                n = 7'h00;
            end else begin
                n = a + 7'd1;
            end
        end else begin
            if (a == 7'h00) begin
                n = 7'h4F;
            end else if (a == 7'h40) begin
                n = 7'h0F;
            end else begin
                n = a - 7'd1;
            end
        end
        return n;
    endfunction

    // Commit strobe on the first cycle after EN falls; writes need the bus idle.
    always_comb begin
        commit_s = en_q_r & ~lcd_en;
        accept_s = commit_s & ~rw_q_r & ~busy_s;
    end

    // Read-back mux for the currently addressed byte or the status word.
    always_comb begin
        rd_data_s = 8'h00;
        if (lcd_rs) begin
            if (is_mapped(ac_r)) begin
                rd_data_s = ddram_r[ram_idx(ac_r)];
            end else begin
                rd_data_s = 8'h20;
            end
        end else begin
            rd_data_s = {busy_s, ac_r};
        end
    end

    // Flatten DDRAM: line0 occupies the upper half, column 0 at the top byte.
    always_comb begin
        ddram_flat = {256{1'b0}};
        for (int i = 0; i < 32; i++) begin
            ddram_flat[255 - 8*i -: 8] = ddram_r[i];
        end
    end

`ifdef LCD_RESP_BUSY_EN
    localparam int CNT_W = $clog2(BUSY_LONG + 1);
    localparam logic [CNT_W-1:0] SHORT_LD = CNT_W'(BUSY_SHORT);
    localparam logic [CNT_W-1:0] LONG_LD  = CNT_W'(BUSY_LONG);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] busy_cnt_r;
    logic             busy_r;
    logic             long_s;

    // Clear (0x01) and Return Home (0x02/0x03) take the long busy time.
    always_comb begin
        long_s = ~rs_q_r & (data_q_r[7:2] == 6'b000000) & (data_q_r[1:0] != 2'b00);
    end

    // Busy countdown; busy_r mirrors (count != 0) one register stage ahead.
    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            busy_cnt_r <= {CNT_W{1'b0}};
            busy_r     <= 1'b0;
        end else if (accept_s) begin
            busy_cnt_r <= long_s ? LONG_LD : SHORT_LD;
            busy_r     <= 1'b1;
        end else if (busy_cnt_r != {CNT_W{1'b0}}) begin
            busy_cnt_r <= busy_cnt_r - CNT_ONE;
            busy_r     <= (busy_cnt_r != CNT_ONE);
        end else begin
            busy_cnt_r <= busy_cnt_r;
            busy_r     <= 1'b0;
        end
    end

    assign busy_s = busy_r;
`else
    assign busy_s = 1'b0;
`endif

    // Bus capture, read-data registers and the instruction/data decoder.
    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            en_q_r       <= 1'b0;
            rs_q_r       <= 1'b0;
            rw_q_r       <= 1'b0;
            data_q_r     <= 8'h00;
            for (int i = 0; i < 32; i++) begin
                ddram_r[i] <= 8'h20;
            end
            ac_r         <= 7'h00;
            id_r         <= 1'b1;
            cg_mode_r    <= 1'b0;
            display_on_r <= 1'b0;
            cursor_on_r  <= 1'b0;
            blink_on_r   <= 1'b0;
            err_r        <= 1'b0;
            data_out_r   <= 8'h00;
            data_oe_r    <= 1'b0;
        end else begin
            en_q_r <= lcd_en;
            if (lcd_en) begin
                rs_q_r   <= lcd_rs;
                rw_q_r   <= lcd_rw;
                data_q_r <= lcd_data_in;
            end
            data_oe_r  <= lcd_en & lcd_rw;
            data_out_r <= (lcd_en & lcd_rw) ? rd_data_s : 8'h00;

            if (commit_s) begin
                if (rw_q_r) begin
                    // Reads are never blocked by busy; data reads advance ac.
                    if (rs_q_r) begin
                        ac_r <= step_ac(ac_r, id_r);
                    end
                end else if (!accept_s) begin
                    err_r <= 1'b1;
                end else if (rs_q_r) begin
                    if (cg_mode_r) begin
                        // CGRAM is not modelled: byte dropped, ac held.
                    end else if (is_mapped(ac_r)) begin
                        ddram_r[ram_idx(ac_r)] <= data_q_r;
                        ac_r <= step_ac(ac_r, id_r);
                    end else begin
                        err_r <= 1'b1;
                        ac_r  <= step_ac(ac_r, id_r);
                    end
                end else begin
                    casez (data_q_r)
                        8'b1???????: begin
                            ac_r      <= data_q_r[6:0];
                            cg_mode_r <= 1'b0;
                            if (!is_mapped(data_q_r[6:0])) begin
                                err_r <= 1'b1;
                            end
                        end
                        8'b01??????: cg_mode_r <= 1'b1;
                        8'b001?????: begin
                            // Only the 8-bit bus width is supported.
                            if (!data_q_r[4]) begin
                                err_r <= 1'b1;
                            end
                        end
                        8'b0001????: begin
                            // Cursor/display shift leaves DDRAM and ac alone.
                        end
                        8'b00001???: begin
                            display_on_r <= data_q_r[2];
                            cursor_on_r  <= data_q_r[1];
                            blink_on_r   <= data_q_r[0];
                        end
                        8'b000001??: id_r <= data_q_r[1];
                        8'b0000001?: ac_r <= 7'h00;
                        8'b00000001: begin
                            for (int i = 0; i < 32; i++) begin
                                ddram_r[i] <= 8'h20;
                            end
                            ac_r      <= 7'h00;
                            id_r      <= 1'b1;
                            cg_mode_r <= 1'b0;
                        end
                        default: begin
                            // 0x00 is not an instruction; only busy is loaded.
                        end
                    endcase
                end
            end
        end
    end

    assign lcd_data_out = data_out_r;
    assign data_oe      = data_oe_r;
    assign ac           = ac_r;
    assign display_on   = display_on_r;
    assign cursor_on    = cursor_on_r;
    assign blink_on     = blink_on_r;
    assign busy         = busy_s;
    assign err          = err_r;

endmodule

// File: tb/tb_lcd_bus_responder.sv
// Self-checking bench for lcd_bus_responder: a directed table, hand-written
// corner sequences and randomized transactions against a behavioural model.
module tb_lcd_bus_responder;

    localparam int S = 12;
    localparam int L = 40;
`ifdef LCD_RESP_BUSY_EN
    localparam bit BUSY_MODEL = 1'b1;
`else
    localparam bit BUSY_MODEL = 1'b0;
`endif

    logic         CLOCK_50 = 1'b0;
    logic         rst = 1'b1;
    logic         lcd_en = 1'b0;
    logic         lcd_rs = 1'b0;
    logic         lcd_rw = 1'b0;
    logic [7:0]   lcd_data_in = 8'h00;
    logic [7:0]   lcd_data_out;
    logic         data_oe;
    logic [255:0] ddram_flat;
    logic [6:0]   ac;
    logic         display_on, cursor_on, blink_on, busy, err;

    lcd_bus_responder #(.BUSY_SHORT(S), .BUSY_LONG(L)) dut (
        .CLOCK_50(CLOCK_50), .rst(rst), .lcd_en(lcd_en), .lcd_rs(lcd_rs),
        .lcd_rw(lcd_rw), .lcd_data_in(lcd_data_in), .lcd_data_out(lcd_data_out),
        .data_oe(data_oe), .ddram_flat(ddram_flat), .ac(ac),
        .display_on(display_on), .cursor_on(cursor_on), .blink_on(blink_on),
        .busy(busy), .err(err)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // Reference model: whole 128-byte address space, flags, busy end edge.
    logic [7:0] mem [0:127];
    logic [6:0] m_ac;
    logic       m_id, m_cg, m_disp, m_cur, m_blk, m_err;
    int         busy_end;

    task automatic tick();
        @(posedge CLOCK_50);
        cyc++;
        #1;
    endtask

    function automatic bit mapped(input logic [6:0] a);
        return (a < 7'd16) || (a >= 7'd64 && a < 7'd80);
    endfunction

    function automatic logic [6:0] step(input logic [6:0] a, input logic inc);
        int n;
        if (inc) n = (a == 7'd15) ? 64 : (a == 7'd79) ? 0 : (int'(a) + 1) % 128;
        else     n = (a == 7'd0) ? 79 : (a == 7'd64) ? 15 : (int'(a) + 127) % 128;
        return 7'(n);
    endfunction

    // Busy as seen after edge number y: high for edges commit .. commit+N-1.
    function automatic bit busy_after(input int y);
        return BUSY_MODEL && (y < busy_end);
    endfunction

    task automatic cmp(input string name, input logic [255:0] act, input logic [255:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 128; i++) mem[i] = 8'h20;
        m_ac = 7'h00; m_id = 1'b1; m_cg = 1'b0;
        m_disp = 1'b0; m_cur = 1'b0; m_blk = 1'b0; m_err = 1'b0;
        busy_end = 0;
    endtask

    task automatic model_commit(input bit rs, input bit rw, input logic [7:0] d);
        if (rw) begin
            if (rs) m_ac = step(m_ac, m_id);
        end else if (busy_after(cyc - 1)) begin
            m_err = 1'b1;
        end else begin
            busy_end = cyc + ((!rs && d >= 8'd1 && d <= 8'd3) ? L : S);
            if (rs) begin
                if (!m_cg) begin
                    if (mapped(m_ac)) mem[m_ac] = d;
                    else m_err = 1'b1;
                    m_ac = step(m_ac, m_id);
                end
            end else if (d >= 8'h80) begin
                m_ac = d[6:0]; m_cg = 1'b0;
                if (!mapped(d[6:0])) m_err = 1'b1;
            end else if (d >= 8'h40) m_cg = 1'b1;
            else if (d >= 8'h20) begin
                if (!d[4]) m_err = 1'b1;
            end else if (d >= 8'h10) begin
            end else if (d >= 8'h08) begin
                m_disp = d[2]; m_cur = d[1]; m_blk = d[0];
            end else if (d >= 8'h04) m_id = d[1];
            else if (d >= 8'h02) m_ac = 7'h00;
            else if (d == 8'h01) begin
                for (int i = 0; i < 128; i++) mem[i] = 8'h20;
                m_ac = 7'h00; m_id = 1'b1; m_cg = 1'b0;
            end
        end
    endtask

    task automatic check_all();
        logic [255:0] ef;
        for (int k = 0; k < 16; k++) begin
            ef[255 - 8*k -: 8] = mem[k];
            ef[127 - 8*k -: 8] = mem[64 + k];
        end
        cmp("ddram_flat", ddram_flat, ef);
        cmp("ac", ac, m_ac);
        cmp("display_on", display_on, m_disp);
        cmp("cursor_on", cursor_on, m_cur);
        cmp("blink_on", blink_on, m_blk);
        cmp("busy", busy, busy_after(cyc));
        cmp("err", err, m_err);
        cmp("data_oe_idle", data_oe, 1'b0);
    endtask

    task automatic do_reset();
        lcd_en = 1'b0; rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        model_reset();
    endtask

    // One bus transaction: EN high for 'hold' cycles, then the commit edge.
    task automatic txn(input bit rs, input bit rw, input logic [7:0] d, input int hold);
        logic [7:0] exp_rd;
        lcd_rs = rs; lcd_rw = rw; lcd_data_in = d; lcd_en = 1'b1;
        for (int h = 0; h < hold; h++) begin
            tick();
            if (rw) begin
                if (rs) exp_rd = mapped(m_ac) ? mem[m_ac] : 8'h20;
                else    exp_rd = {busy_after(cyc - 1), m_ac};
                cmp("data_oe", data_oe, 1'b1);
                cmp("rd_data", lcd_data_out, exp_rd);
            end
        end
        lcd_en = 1'b0;
        tick();
        model_commit(rs, rw, d);
        check_all();
    endtask

    function automatic logic [7:0] byte_at(input int pos);
        return ddram_flat[255 - 8*pos -: 8];
    endfunction

    typedef struct {
        bit         rs;
        logic [7:0] d;
        logic [6:0] exp_ac;
        bit         exp_err;
        bit         exp_disp;
        int         pos;
        logic [7:0] exp_byte;
    } vec_t;

    vec_t tbl [12];
    int   n;
    logic [7:0] rd;

    initial begin
        tbl[0]  = '{0, 8'h38, 7'h00, 0, 0, -1, 8'h00};
        tbl[1]  = '{0, 8'h0C, 7'h00, 0, 1, -1, 8'h00};
        tbl[2]  = '{0, 8'h06, 7'h00, 0, 1, -1, 8'h00};
        tbl[3]  = '{0, 8'h80, 7'h00, 0, 1, -1, 8'h00};
        tbl[4]  = '{1, 8'h41, 7'h01, 0, 1,  0, 8'h41};
        tbl[5]  = '{0, 8'h8F, 7'h0F, 0, 1, -1, 8'h00};
        tbl[6]  = '{1, 8'h31, 7'h40, 0, 1, 15, 8'h31};
        tbl[7]  = '{1, 8'h32, 7'h41, 0, 1, 16, 8'h32};
        tbl[8]  = '{0, 8'h04, 7'h41, 0, 1, -1, 8'h00};
        tbl[9]  = '{0, 8'hC0, 7'h40, 0, 1, -1, 8'h00};
        tbl[10] = '{1, 8'h5A, 7'h0F, 0, 1, 16, 8'h5A};
        tbl[11] = '{0, 8'hA0, 7'h20, 1, 1, -1, 8'h00};

        // Reset state.
        do_reset();
        check_all();
        cmp("reset_flat", ddram_flat, {32{8'h20}});

        // Directed table with busy waits between writes.
        for (int i = 0; i < 12; i++) begin
            txn(tbl[i].rs, 1'b0, tbl[i].d, 1);
            cmp("tbl_ac", ac, tbl[i].exp_ac);
            cmp("tbl_err", err, tbl[i].exp_err);
            cmp("tbl_display_on", display_on, tbl[i].exp_disp);
            if (tbl[i].pos >= 0) cmp("tbl_byte", byte_at(tbl[i].pos), tbl[i].exp_byte);
            repeat (L + 4) tick();
        end

        // Clear: busy length.
        do_reset();
        txn(1'b0, 1'b0, 8'h01, 1);
        n = 0;
        while (busy && n < L + 20) begin
            n++;
            tick();
        end
        cmp("busy_len_clear", n, BUSY_MODEL ? L : 0);

        // Clear followed by a data write 10 cycles later.
        do_reset();
        txn(1'b0, 1'b0, 8'h01, 1);
        repeat (8) tick();
        txn(1'b1, 1'b0, 8'h5A, 1);
        cmp("clear_then_data_err", err, BUSY_MODEL);
        cmp("clear_then_data_byte", byte_at(0), BUSY_MODEL ? 8'h20 : 8'h5A);
        repeat (L + 4) tick();

        // Status read right after a write.
        do_reset();
        txn(1'b0, 1'b0, 8'h06, 1);
        lcd_rs = 1'b0; lcd_rw = 1'b1; lcd_en = 1'b1;
        tick();
        rd = lcd_data_out;
        cmp("status_read", rd, {BUSY_MODEL, 7'h00});
        lcd_en = 1'b0;
        tick();
        model_commit(1'b0, 1'b1, 8'h00);
        check_all();

        // Write commit on the same edge busy expires: rejected.
        do_reset();
        txn(1'b0, 1'b0, 8'h06, 1);
        repeat (S - 2) tick();
        txn(1'b0, 1'b0, 8'h0C, 1);
        cmp("expiry_edge_err", err, BUSY_MODEL);
        cmp("expiry_edge_disp", display_on, !BUSY_MODEL);

        // One cycle later: accepted.
        do_reset();
        txn(1'b0, 1'b0, 8'h06, 1);
        repeat (S - 1) tick();
        txn(1'b0, 1'b0, 8'h0C, 1);
        cmp("after_expiry_err", err, 1'b0);
        cmp("after_expiry_disp", display_on, 1'b1);

        // Reset in the middle of a data write abandons it.
        do_reset();
        lcd_rs = 1'b1; lcd_rw = 1'b0; lcd_data_in = 8'h51; lcd_en = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; lcd_en = 1'b0;
        tick();
        model_reset();
        check_all();
        cmp("rst_mid_ac", ac, 7'h00);
        cmp("rst_mid_byte", byte_at(0), 8'h20);

        // Randomized transactions against the model.
        do_reset();
        for (int t = 0; t < 400; t++) begin
            logic [7:0] d;
            bit rs, rw;
            if (t % 50 == 0) do_reset();
            rs = 1'($urandom_range(0, 1));
            rw = ($urandom_range(0, 3) == 0);
            d = 8'($urandom);
            if ($urandom_range(0, 2) == 0) d = {1'b1, 1'($urandom_range(0, 1)), 2'b00, 4'($urandom)};
            if (d[7:4] == 4'h2 && $urandom_range(0, 3) != 0) d[4] = 1'b1;
            txn(rs, rw, d, int'($urandom_range(1, 3)));
            repeat ($urandom_range(0, S + 3)) tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
